// File: rtl/barrel_pkg.sv
// barrel_pkg: shared types and helpers for the pipelined barrel shifter.
package barrel_pkg;

  typedef enum logic [2:0] {
    SLL = 3'd0,
    SRL = 3'd1,
    SRA = 3'd2,
    ROL = 3'd3,
    ROR = 3'd4
  } shift_mode_e;

  localparam logic [2:0] RSVD_LO = 3'd5;
  localparam logic [2:0] RSVD_HI = 3'd7;

  function automatic int shw_of(input int width);
    return $clog2(width);
  endfunction

  function automatic logic is_rsvd(input shift_mode_e m);
    return m inside {[RSVD_LO:RSVD_HI]};
  endfunction

endpackage

// File: rtl/barrel_shift_pipe_if.sv
// barrel_shift_pipe_if: operand/result valid-ready bundle.
interface barrel_shift_pipe_if #(
  parameter int WIDTH = 32
);
  import barrel_pkg::*;

  localparam int SHW = shw_of(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  shift_mode_e      in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;

  modport slave (
    input  in_valid, in_data, in_amt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_err
  );

  modport master (
    output in_valid, in_data, in_amt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

endinterface

// File: rtl/barrel_stage.sv
// barrel_stage: one combinational 2^K shift/rotate step.
module barrel_stage
  import barrel_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int K     = 0
) (
  input  logic [WIDTH-1:0] din,
  input  shift_mode_e      mode,
  input  logic             sign,
  input  logic             en,
  output logic [WIDTH-1:0] dout
);

  localparam int S = 1 << K;

  logic [WIDTH-1:0] fill;

  assign fill = {WIDTH{sign}} << (WIDTH - S);

  always_comb begin
    dout = din;
    if (en) begin
      unique case (mode)
        SLL:     dout = din << S;
        SRL:     dout = din >> S;
        SRA:     dout = (din >> S) | fill;
        ROL:     dout = (din << S) | (din >> (WIDTH - S));
        ROR:     dout = (din >> S) | (din << (WIDTH - S));
        default: dout = din;
      endcase
    end
  end

endmodule

// File: rtl/barrel_shift_pipe.sv
// barrel_shift_pipe: log2(WIDTH)-stage pipelined barrel shifter
// with a single global advance enable.
module barrel_shift_pipe
  import barrel_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic               clk,
  input logic               rst_n,
  barrel_shift_pipe_if.slave bus
);

  localparam int SHW = shw_of(WIDTH);

  logic adv;

  assign adv         = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready = adv;

  for (genvar k = 0; k < SHW; k++) begin : g_st
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;
    logic [SHW-1:k]   amt_in;
    shift_mode_e      mode_in;
    logic             sign_in;
    logic             vld_in;
    logic             err_in;
    logic             vld_d;
    logic             vld_q;
    logic             err_d;
    logic             err_q;

    // Reserved codes enter as zero so every later step keeps them zero.
    if (k == 0) begin : g_head
      assign din     = is_rsvd(bus.in_mode) ? '0 : bus.in_data;
      assign amt_in  = bus.in_amt;
      assign mode_in = bus.in_mode;
      assign sign_in = bus.in_data[WIDTH-1];
      assign vld_in  = bus.in_valid;
      assign err_in  = is_rsvd(bus.in_mode);
    end else begin : g_tail
      assign din     = g_st[k-1].data_q;
      assign amt_in  = g_st[k-1].g_fwd.amt_q;
      assign mode_in = g_st[k-1].g_fwd.mode_q;
      assign sign_in = g_st[k-1].g_fwd.sign_q;
      assign vld_in  = g_st[k-1].vld_q;
      assign err_in  = g_st[k-1].err_q;
    end

    barrel_stage #(
      .WIDTH (WIDTH),
      .K     (k)
    ) u_stage (
      .din  (din),
      .mode (mode_in),
      .sign (sign_in),
      .en   (amt_in[k]),
      .dout (dout)
    );

    always_comb begin
      data_d = data_q;
      vld_d  = vld_q;
      err_d  = err_q;
      if (adv) begin
        data_d = dout;
        vld_d  = vld_in;
        err_d  = err_in;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q <= '0;
        vld_q  <= 1'b0;
        err_q  <= 1'b0;
      end else begin
        data_q <= data_d;
        vld_q  <= vld_d;
        err_q  <= err_d;
      end
    end

    // Only the amount bits still ahead are carried forward.
    if (k < SHW - 1) begin : g_fwd
      logic [SHW-1:k+1] amt_d;
      logic [SHW-1:k+1] amt_q;
      shift_mode_e      mode_d;
      shift_mode_e      mode_q;
      logic             sign_d;
      logic             sign_q;

      always_comb begin
        amt_d  = amt_q;
        mode_d = mode_q;
        sign_d = sign_q;
        if (adv) begin
          amt_d  = amt_in[SHW-1:k+1];
          mode_d = mode_in;
          sign_d = sign_in;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          amt_q  <= '0;
          mode_q <= SLL;
          sign_q <= 1'b0;
        end else begin
          amt_q  <= amt_d;
          mode_q <= mode_d;
          sign_q <= sign_d;
        end
      end
    end
  end

  assign bus.out_valid = g_st[SHW-1].vld_q;
  assign bus.out_data  = g_st[SHW-1].data_q;
  assign bus.out_err   = g_st[SHW-1].err_q;

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// tb_barrel_shift_pipe: randomized and directed checks of the
// barrel shifter against a plain-arithmetic reference model.
module tb_barrel_shift_pipe;
  import barrel_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  barrel_shift_pipe_if #(.WIDTH(8))  b8 ();
  barrel_shift_pipe_if #(.WIDTH(64)) b64 ();

  barrel_shift_pipe #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b8)
  );

  barrel_shift_pipe #(.WIDTH(64)) dut64 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b64)
  );

  typedef struct {
    logic [63:0] d;
    logic        e;
    int          c;
  } exp_t;

  exp_t q8[$];
  exp_t q64[$];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int cyc_s  = 0;

  logic        acc8, fire8, ir8, ov8, oe8;
  logic [7:0]  od8;
  logic        acc64, fire64, oe64;
  logic [63:0] od64;

  function automatic logic [63:0] model(input logic [63:0] d, input int a,
                                        input int m, input int w);
    logic [63:0] mask;
    logic [63:0] dm;
    logic [63:0] r;
    longint      s;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    dm   = d & mask;
    s    = dm[w-1] ? longint'(dm | ~mask) : longint'(dm);
    case (m)
      0:       r = dm << a;
      1:       r = dm >> a;
      2:       r = 64'(s >>> a);
      3:       r = (dm << a) | (dm >> (w - a));
      4:       r = (dm >> a) | (dm << (w - a));
      default: r = '0;
    endcase
    return r & mask;
  endfunction

  // Samples both handshakes mid-cycle, logs accepted ops, then steps a cycle.
  task automatic tick();
    @(negedge clk);
    cyc_s  = cyc;
    acc8   = b8.in_valid && b8.in_ready;
    ir8    = b8.in_ready;
    ov8    = b8.out_valid;
    od8    = b8.out_data;
    oe8    = b8.out_err;
    fire8  = ov8 && b8.out_ready;
    acc64  = b64.in_valid && b64.in_ready;
    od64   = b64.out_data;
    oe64   = b64.out_err;
    fire64 = b64.out_valid && b64.out_ready;
    if (acc8)
      q8.push_back('{d: model(64'(b8.in_data), int'(b8.in_amt),
                              int'(b8.in_mode), 8),
                     e: int'(b8.in_mode) >= 5, c: cyc});
    if (acc64)
      q64.push_back('{d: model(b64.in_data, int'(b64.in_amt),
                               int'(b64.in_mode), 64),
                      e: int'(b64.in_mode) >= 5, c: cyc});
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    b8.in_valid   = 1'b0;
    b8.in_data    = '0;
    b8.in_amt     = '0;
    b8.in_mode    = SLL;
    b8.out_ready  = 1'b0;
    b64.in_valid  = 1'b0;
    b64.in_data   = '0;
    b64.in_amt    = '0;
    b64.in_mode   = SLL;
    b64.out_ready = 1'b0;
    #3;
    n_chk++;
    if (b8.out_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", b8.out_valid);
    else n_pass++;
    n_chk++;
    if (b8.out_data !== 8'h00) $display("FAIL rst_data got %h want 00", b8.out_data);
    else n_pass++;
    n_chk++;
    if (b8.out_err !== 1'b0) $display("FAIL rst_err got %b want 0", b8.out_err);
    else n_pass++;
    n_chk++;
    if (b8.in_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", b8.in_ready);
    else n_pass++;
    n_chk++;
    if (b64.out_valid !== 1'b0) $display("FAIL rst_valid64 got %b want 0", b64.out_valid);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    rst_n         = 1'b1;
    b8.out_ready  = 1'b1;
    b64.out_ready = 1'b1;
  endtask

  task automatic test_modes();
    logic [7:0] want [5] = '{8'hA8, 8'h16, 8'hF6, 8'hAD, 8'hB6};
    int   t0 = 0;
    int   k  = 0;
    exp_t e;
    for (int i = 0; i < 16 && k < 5; i++) begin
      b8.in_valid = i < 5;
      b8.in_data  = 8'hB5;
      b8.in_amt   = 3'd3;
      b8.in_mode  = shift_mode_e'((i < 5) ? i : 0);
      tick();
      if (i == 0) t0 = cyc_s;
      if (fire8) begin
        e = q8.pop_front();
        n_chk++;
        if (od8 !== want[k]) $display("FAIL modes_data[%0d] got %h want %h", k, od8, want[k]);
        else n_pass++;
        n_chk++;
        if (oe8 !== 1'b0) $display("FAIL modes_err[%0d] got %b want 0", k, oe8);
        else n_pass++;
        n_chk++;
        if (cyc_s !== t0 + 3 + k) $display("FAIL modes_lat[%0d] got %0d want %0d", k, cyc_s, t0 + 3 + k);
        else n_pass++;
        k++;
      end
    end
    b8.in_valid = 1'b0;
    n_chk++;
    if (k !== 5) $display("FAIL modes_count got %0d want 5", k);
    else n_pass++;
  endtask

  task automatic test_sra();
    logic [7:0] want [9] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8,
                             8'hFC, 8'hFE, 8'hFF, 8'h01};
    int   k = 0;
    exp_t e;
    for (int i = 0; i < 24 && k < 9; i++) begin
      b8.in_valid = i < 9;
      b8.in_data  = 8'h80;
      b8.in_amt   = 3'((i < 8) ? i : 7);
      b8.in_mode  = (i < 8) ? SRA : SRL;
      tick();
      if (fire8) begin
        e = q8.pop_front();
        n_chk++;
        if (od8 !== want[k]) $display("FAIL sra_data[%0d] got %h want %h", k, od8, want[k]);
        else n_pass++;
        k++;
      end
    end
    b8.in_valid = 1'b0;
    n_chk++;
    if (k !== 9) $display("FAIL sra_count got %0d want 9", k);
    else n_pass++;
  endtask

  task automatic test_reserved();
    logic [7:0] want_d [2] = '{8'h00, 8'h78};
    logic       want_e [2] = '{1'b1, 1'b0};
    int   k = 0;
    exp_t e;
    for (int i = 0; i < 12 && k < 2; i++) begin
      b8.in_valid = i < 2;
      b8.in_data  = (i == 0) ? 8'hFF : 8'h3C;
      b8.in_amt   = (i == 0) ? 3'd5 : 3'd1;
      b8.in_mode  = (i == 0) ? shift_mode_e'(3'd6) : SLL;
      tick();
      if (fire8) begin
        e = q8.pop_front();
        n_chk++;
        if (od8 !== want_d[k] || oe8 !== want_e[k])
          $display("FAIL rsvd[%0d] got %h/%b want %h/%b", k, od8, oe8, want_d[k], want_e[k]);
        else n_pass++;
        k++;
      end
    end
    b8.in_valid = 1'b0;
    n_chk++;
    if (k !== 2) $display("FAIL rsvd_count got %0d want 2", k);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [7:0] dat [10];
    logic [2:0] amt [10];
    logic [2:0] md  [10];
    logic [7:0] hold = '0;
    int   issued = 0;
    int   k = 0;
    exp_t e;
    for (int j = 0; j < 10; j++) begin
      dat[j] = 8'($urandom);
      amt[j] = 3'($urandom_range(0, 7));
      md[j]  = 3'($urandom_range(0, 4));
    end
    for (int i = 0; i < 60 && k < 10; i++) begin
      b8.in_valid  = issued < 10;
      b8.in_data   = dat[(issued < 10) ? issued : 9];
      b8.in_amt    = amt[(issued < 10) ? issued : 9];
      b8.in_mode   = shift_mode_e'(md[(issued < 10) ? issued : 9]);
      b8.out_ready = !(i >= 5 && i < 9);
      tick();
      if (acc8) issued++;
      if (i >= 5 && i < 9) begin
        if (i == 5) hold = od8;
        n_chk++;
        if (ir8 !== 1'b0 || ov8 !== 1'b1)
          $display("FAIL stall_ready[%0d] got rdy=%b vld=%b want 0/1", i, ir8, ov8);
        else n_pass++;
        n_chk++;
        if (od8 !== hold) $display("FAIL stall_hold[%0d] got %h want %h", i, od8, hold);
        else n_pass++;
      end
      if (fire8) begin
        e = q8.pop_front();
        n_chk++;
        if (od8 !== e.d[7:0] || oe8 !== e.e)
          $display("FAIL stall_data[%0d] got %h/%b want %h/%b", k, od8, oe8, e.d[7:0], e.e);
        else n_pass++;
        k++;
      end
    end
    b8.in_valid  = 1'b0;
    b8.out_ready = 1'b1;
    n_chk++;
    if (k !== 10 || q8.size() !== 0)
      $display("FAIL stall_count got %0d left %0d want 10 left 0", k, q8.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int t0   = 0;
    int seen = 0;
    b8.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b8.in_valid = 1'b1;
      b8.in_data  = 8'($urandom);
      b8.in_amt   = 3'($urandom_range(0, 7));
      b8.in_mode  = shift_mode_e'($urandom_range(0, 4));
      tick();
    end
    b8.in_valid = 1'b0;
    n_chk++;
    if (b8.out_valid !== 1'b1) $display("FAIL midrst_pre got %b want 1", b8.out_valid);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (b8.out_valid !== 1'b0 || b8.out_data !== 8'h00 || b8.out_err !== 1'b0)
      $display("FAIL midrst_clear got %b/%h/%b want 0/00/0", b8.out_valid, b8.out_data, b8.out_err);
    else n_pass++;
    n_chk++;
    if (b8.in_ready !== 1'b1) $display("FAIL midrst_ready got %b want 1", b8.in_ready);
    else n_pass++;
    q8.delete();
    q64.delete();
    tick();
    tick();
    rst_n       = 1'b1;
    b8.in_valid = 1'b1;
    b8.in_data  = 8'h5A;
    b8.in_amt   = 3'd2;
    b8.in_mode  = ROL;
    tick();
    t0 = cyc_s;
    b8.in_valid = 1'b0;
    n_chk++;
    if (acc8 !== 1'b1) $display("FAIL midrst_accept got %b want 1", acc8);
    else n_pass++;
    for (int j = 0; j < 6; j++) begin
      tick();
      if (ov8) begin
        seen++;
        n_chk++;
        if (cyc_s !== t0 + 3 || od8 !== 8'h69 || oe8 !== 1'b0)
          $display("FAIL midrst_out got c=%0d %h/%b want c=%0d 69/0", cyc_s, od8, oe8, t0 + 3);
        else n_pass++;
      end
    end
    n_chk++;
    if (seen !== 1) $display("FAIL midrst_count got %0d want 1", seen);
    else n_pass++;
    q8.delete();
  endtask

  task automatic test_random8();
    logic       pv = 1'b0;
    logic [7:0] pd = '0;
    exp_t e;
    for (int i = 0; i < 400; i++) begin
      if (!(b8.in_valid && !acc8)) begin
        b8.in_valid = (i < 370) && ($urandom_range(0, 3) != 0);
        b8.in_data  = 8'($urandom);
        b8.in_amt   = 3'($urandom_range(0, 7));
        b8.in_mode  = shift_mode_e'($urandom_range(0, 7));
      end
      b8.out_ready = (i >= 370) || ($urandom_range(0, 3) != 0);
      tick();
      if (pv) begin
        n_chk++;
        if (!ov8 || od8 !== pd)
          $display("FAIL rnd8_stable got %b/%h want 1/%h", ov8, od8, pd);
        else n_pass++;
      end
      pv = ov8 && !fire8;
      pd = od8;
      if (fire8) begin
        n_chk++;
        if (q8.size() == 0) $display("FAIL rnd8_extra got %h want none", od8);
        else begin
          e = q8.pop_front();
          if (od8 !== e.d[7:0] || oe8 !== e.e)
            $display("FAIL rnd8_data got %h/%b want %h/%b", od8, oe8, e.d[7:0], e.e);
          else n_pass++;
        end
      end
    end
    b8.in_valid = 1'b0;
    n_chk++;
    if (q8.size() !== 0) $display("FAIL rnd8_left got %0d want 0", q8.size());
    else n_pass++;
  endtask

  task automatic test_random64();
    exp_t e;
    for (int i = 0; i < 300; i++) begin
      if (!(b64.in_valid && !acc64)) begin
        b64.in_valid = (i < 270) && ($urandom_range(0, 3) != 0);
        b64.in_data  = {$urandom, $urandom};
        b64.in_amt   = 6'($urandom_range(0, 63));
        b64.in_mode  = shift_mode_e'($urandom_range(0, 7));
      end
      b64.out_ready = (i >= 270) || ($urandom_range(0, 3) != 0);
      tick();
      if (fire64) begin
        n_chk++;
        if (q64.size() == 0) $display("FAIL rnd64_extra got %h want none", od64);
        else begin
          e = q64.pop_front();
          if (od64 !== e.d || oe64 !== e.e)
            $display("FAIL rnd64_data got %h/%b want %h/%b", od64, oe64, e.d, e.e);
          else n_pass++;
        end
      end
    end
    b64.in_valid = 1'b0;
    n_chk++;
    if (q64.size() !== 0) $display("FAIL rnd64_left got %0d want 0", q64.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_modes();
    test_sra();
    test_reserved();
    test_stall();
    test_reset_mid();
    test_random8();
    test_random64();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/barrel_shift_pipe.md
BARREL_SHIFT_PIPE -- requirements
Module: barrel_shift_pipe

Interface
REQ-001 Parameter WIDTH, default 32: data width; SHALL be a power of two, 8 or greater.
REQ-002 Derived constant SHW = log2(WIDTH): shift-amount width and number of pipeline stages.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  input operation is present.
REQ-006 in_ready  output  1  block accepts the input this cycle.
REQ-007 in_data  input  WIDTH  operand.
REQ-008 in_amt  input  SHW  shift amount, 0 to WIDTH-1.
REQ-009 in_mode  input  3  operation code of type shift_mode_e.
REQ-010 out_valid  output  1  result is present.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_data  output  WIDTH  result.
REQ-013 out_err  output  1  result came from a reserved mode code.

Function
REQ-014 Mode encodings SHALL be: SLL=0 (logical left), SRL=1 (logical right), SRA=2 (arithmetic right, sign-fill from bit WIDTH-1), ROL=3 (rotate left), ROR=4 (rotate right).
REQ-015 Codes 5 to 7 are reserved; they SHALL produce out_data=0 and out_err=1. All valid modes SHALL produce out_err=0.
REQ-016 The transfer SHALL happen on a cycle where in_valid and in_ready are both 1; output transfer is the same with out_valid and out_ready.
REQ-017 The datapath SHALL have SHW registered stages. Stage k conditionally shifts or rotates by 2^k, selected by amount bit k, in the direction and fill set by the mode.
REQ-018 Latency SHALL be exactly SHW cycles from the input transfer to out_valid=1, when there is no backpressure.
REQ-019 A single pipeline advance enable SHALL be used: adv = out_ready OR NOT out_valid; in_ready SHALL equal adv.
REQ-020 When adv=0, every stage SHALL hold its data, amount, mode and valid bit unchanged.
REQ-021 When adv=1 and in_valid=0, a bubble (valid=0) SHALL enter stage 0; data carried by a bubble is don't-care.
REQ-022 Throughput SHALL be one operation per cycle while out_ready=1.
REQ-023 in_amt=0 SHALL return in_data unchanged in every valid mode.
REQ-024 For SRA, the sign bit SHALL be captured at stage 0 and carried through the pipeline; intermediate bits SHALL NOT be used to recompute it.
REQ-025 out_data and out_err SHALL stay stable while out_valid=1 and out_ready=0.
REQ-026 Results SHALL leave in acceptance order, with no loss and no duplication.
REQ-027 in_ready=1 with in_valid=0 and out_valid=1 with out_ready=1 in the same cycle is legal; the pipeline SHALL advance by one stage.

Reset
REQ-028 rst_n=0 SHALL immediately clear all stage valid bits: out_valid=0, out_data=0, out_err=0.
REQ-029 During reset, in_ready SHALL read 1.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight operations; no stale result SHALL appear after reset is released.
REQ-031 The first input transfer after rst_n rises SHALL be accepted on the first rising edge with in_valid=1.

Structure
REQ-032 Package barrel_pkg SHALL hold shift_mode_e, the reserved-code range, and a function returning SHW for a given WIDTH.
REQ-033 A sub-module barrel_stage, parameterised by WIDTH and stage index, SHALL implement one combinational 2^k mux step.
REQ-034 barrel_shift_pipe SHALL instantiate barrel_stage SHW times through a generate loop and own all pipeline registers.

Verification (WIDTH=8, latency 3)
REQ-035 Data 0xB5, amount 3, modes SLL/SRL/SRA/ROL/ROR fed back to back -> out_data 0xA8, 0x16, 0xF6, 0xAD, 0xB6 on consecutive cycles, the first appearing 3 cycles after acceptance.
REQ-036 Data 0x80, SRA for amounts 0 to 7 -> 0x80, 0xC0, 0xE0, 0xF0, 0xF8, 0xFC, 0xFE, 0xFF; SRL amount 7 -> 0x01.
REQ-037 Mode 6, data 0xFF -> out_data 0x00 and out_err=1; the next valid op has out_err=0.
REQ-038 Ten ops streamed; out_ready held 0 for 4 cycles mid-stream -> in_ready=0 while stalled, output held stable, all ten results in order.
REQ-039 rst_n pulsed low with 3 ops in flight -> out_valid=0 immediately; no result emerges afterwards; an op issued after release appears 3 cycles later.
REQ-040 Random mode, data and amount with a scoreboard; WIDTH=8 and WIDTH=64 builds -> all results match the reference model.
